optical_pulse_tx: RTL and testbench

OPTICAL_PULSE_TX -- requirements
Module: optical_pulse_tx

---
 rtl/optical_pulse_tx.sv | 159 +++++++++++++++
 tb/tb_optical_pulse_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/optical_pulse_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | optical_pulse_tx : serial byte-to-light framer (start/data/parity/stop)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module optical_pulse_tx #(
    parameter int BIT_CYCLES = 50,
    parameter int PARITY_EN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       led_drive,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] c_last_cnt  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] c_done_cnt  = 16'(BIT_CYCLES - 2);

    state_t      state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [2:0]  idx_q,    idx_d;
    logic [7:0]  shift_q,  shift_d;
    logic        parity_q, parity_d;
    logic        led_q,    led_d;
    logic        ready_q,  ready_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        w_bit_end;

    assign w_bit_end = (cnt_q == c_last_cnt);

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        led_d    = led_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = w_bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                led_d   = 1'b0;
                if (tx_valid && ready_q) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    cnt_d    = 16'd0;
                    idx_d    = 3'd0;
                    led_d    = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    led_d   = shift_q[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            led_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            led_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        led_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    state_d = STOP;
                    led_d   = 1'b0;
                end
            end
            STOP: begin
                if (cnt_q == c_done_cnt) begin
                    done_d = 1'b1;
                end
                if (w_bit_end) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                led_d   = 1'b0;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            led_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            led_q    <= led_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready  = ready_q;
    assign led_drive = led_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_optical_pulse_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_optical_pulse_tx : scoreboard bench, parity and no-parity instances   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_optical_pulse_tx;

    localparam int BC = 4;

    typedef struct packed {
        logic [10:0] slots;   // slot 0 is bit 10
        logic [3:0]  nslots;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d0, d1;
    logic [1:0] v;
    logic [1:0] rdy, led, busy, done;

    always #5 clk = ~clk;

    optical_pulse_tx #(.BIT_CYCLES(BC), .PARITY_EN(1)) u_dut0 (
        .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .led_drive(led[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    optical_pulse_tx #(.BIT_CYCLES(BC), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .led_drive(led[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [10:0] s, input int n);
        exp_t e;
        e.slots  = s;
        e.nslots = 4'(n);
        return e;
    endfunction

    // Monitor: pops one expected frame whenever an instance goes busy.
    logic [1:0] in_frame = 2'b00;
    logic [1:0] rogue    = 2'b00;
    int         cyc[2];
    exp_t       cur[2];

    always @(negedge clk) begin
        int k;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                chk($sformatf("reset_led%0d", i), int'(led[i]), 0);
                chk($sformatf("reset_done%0d", i), int'(done[i]), 0);
                in_frame[i] = 1'b0;
                rogue[i]    = 1'b0;
            end else begin
                if (rogue[i] && !busy[i]) rogue[i] = 1'b0;
                if (!in_frame[i] && !rogue[i] && busy[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_frame%0d: got busy=1 want no frame", i);
                        rogue[i] = 1'b1;
                    end else begin
                        if (i == 0) cur[i] = q0.pop_front();
                        else        cur[i] = q1.pop_front();
                        in_frame[i] = 1'b1;
                        cyc[i]      = 0;
                    end
                end
                if (in_frame[i]) begin
                    k = 10 - cyc[i] / BC;
                    chk($sformatf("led%0d_cyc%0d", i, cyc[i]), int'(led[i]), int'(cur[i].slots[k]));
                    chk($sformatf("busy%0d_cyc%0d", i, cyc[i]), int'(busy[i]), 1);
                    if (done[i]) begin
                        chk($sformatf("done%0d_cycle", i), cyc[i] + 1, int'(cur[i].nslots) * BC);
                        in_frame[i] = 1'b0;
                    end else if (cyc[i] + 1 >= int'(cur[i].nslots) * BC) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL done%0d_missing: got no done by cycle %0d want done", i, cyc[i] + 1);
                        in_frame[i] = 1'b0;
                    end
                    cyc[i]++;
                end else if (done[i] && !rogue[i]) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stray_done%0d: got done=1 want 0", i);
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] b, input exp_t e);
        bit ok = 1'b0;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rdy[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("ready_wait%0d", i), int'(ok), 1);
        if (i == 0) d0 = b;
        else        d1 = b;
        v[i] = 1'b1;
        @(posedge clk);
        #1 v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (done[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("done_wait%0d", i), int'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g;
        bit  ok;
        reset = 1'b0;
        v     = 2'b00;
        d0    = 8'h00;
        d1    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", int'(rdy[0]), 0);
        chk("reset_ready1", int'(rdy[1]), 0);
        chk("reset_busy0", int'(busy[0]), 0);
        chk("reset_busy1", int'(busy[1]), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ready0", int'(rdy[0]), 1);
        chk("release_ready1", int'(rdy[1]), 1);

        send(0, 8'hA5, mk(11'b11010010100, 11));
        wait_done(0);
        send(0, 8'h07, mk(11'b11110000010, 11));
        wait_done(0);
        send(0, 8'h03, mk(11'b11100000000, 11));
        wait_done(0);

        // back-to-back with tx_valid held high
        q0.push_back(mk(11'b10000000000, 11));
        q0.push_back(mk(11'b11111111100, 11));
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rdy[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_ready", int'(ok), 1);
        d0 = 8'h00;
        v[0] = 1'b1;
        @(posedge clk);
        #1 d0 = 8'hFF;
        wait_done(0);
        g = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1 g++;
            if (busy[0]) break;
        end
        chk("b2b_gap", g, 2);
        v[0] = 1'b0;
        wait_done(0);

        send(1, 8'h80, mk(11'b10000000100, 10));
        wait_done(1);

        // pulse during a busy frame is ignored
        send(0, 8'h3C, mk(11'b10011110000, 11));
        repeat (10) @(posedge clk);
        #1;
        d0   = 8'hFF;
        v[0] = 1'b1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        wait_done(0);
        repeat (60) @(posedge clk);
        #1 chk("ignored_busy", int'(busy[0]), 0);

        // reset during data bit 3 (cycles 17..20 after acceptance)
        send(0, 8'hA5, mk(11'b11010010100, 11));
        repeat (17) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_led", int'(led[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_ready", int'(rdy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        d0   = 8'h3C;
        v[0] = 1'b1;
        q0.push_back(mk(11'b10011110000, 11));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", int'(rdy[0]), 1);
        chk("rel_not_accepted", int'(busy[0]), 0);
        @(posedge clk);
        #1;
        chk("rel_accepted", int'(busy[0]), 1);
        v[0] = 1'b0;
        wait_done(0);

        repeat (10) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
